pipe_ctrl: RTL and testbench

Parametrised pipeline-register chain with a per-stage valid bit. It replaces hand-written stage latches in the CPU top level, for example the decode/execute/memory/writeback registers. It supports N stages, bus-wait stalls from any stage, bubble insertion, and branch/exception flush of younger stages, all from one uniform control rule. Each stage carries one opaque payload; the core packs control bits, register indices, operands and the PC into it.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage.sv | 40 ++++
 rtl/pipe_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the per-stage update decision for the pipe_ctrl register chain.
package pipe_pkg;

   localparam int PIPE_STAGES_DEF = 4;
   localparam int PIPE_WIDTH_DEF  = 128;

   typedef enum logic [1:0] {
      HOLD,
      LOAD,
      BUBBLE,
      KILL
   } stage_ctl_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register slot: payload plus valid bit, updated by a decoded stage_ctl_t.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int WIDTH = PIPE_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  stage_ctl_t       ctl,
   input  logic             prevValid,
   input  logic [WIDTH-1:0] prevData,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // NOTE: sequential state uses non-blocking assignments so every stage samples its
   // neighbour's pre-edge value; the payload is reset too, so killed/bubble slots read 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         case (ctl)
            HOLD: begin
            end
            LOAD: begin
               valid <= prevValid;
               data  <= prevData;
            end
            BUBBLE, KILL: begin
               valid <= 1'b0;
               data  <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage pipeline register chain with stall, bubble and flush control.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int STAGES = PIPE_STAGES_DEF,
   parameter int WIDTH  = PIPE_WIDTH_DEF
`ifdef PIPE_PERF_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    in_valid,
   input  logic [WIDTH-1:0]        in_data,
   output logic                    in_ready,
   input  logic [STAGES-1:0]       stall_req,
   input  logic [STAGES-1:0]       flush,
   output logic [STAGES-1:0]       stage_valid,
   output logic [STAGES*WIDTH-1:0] stage_data,
   output logic                    out_fire
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]        perf_stall,
   output logic [CNT_W-1:0]        perf_flush,
   output logic [CNT_W-1:0]        perf_retire
`endif
);

   logic [STAGES-1:0] freeze;
   logic [STAGES-1:0] kill;
   logic [STAGES-1:0] validQ;
   logic [WIDTH-1:0]  dataQ [STAGES];

   // Suffix ORs from the oldest stage down: a stall holds everything younger, a flush
   // kills everything strictly younger.
   always_comb begin
      logic stallAcc;
      logic flushAcc;
      stallAcc = 1'b0;
      flushAcc = 1'b0;
      freeze   = '0;
      kill     = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         kill[i]   = flushAcc;
         stallAcc  = stallAcc | stall_req[i];
         flushAcc  = flushAcc | flush[i];
         freeze[i] = stallAcc;
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : gStage
      stage_ctl_t       ctl;
      logic             prevValid;
      logic [WIDTH-1:0] prevData;

      if (i == 0) begin : gHead
         assign prevValid = in_valid;
         assign prevData  = in_data;
         always_comb begin
            if (kill[0])        ctl = KILL;
            else if (freeze[0]) ctl = HOLD;
            else                ctl = LOAD;
         end
      end else begin : gBody
         assign prevValid = validQ[i-1];
         assign prevData  = dataQ[i-1];
         always_comb begin
            if (kill[i])          ctl = KILL;
            else if (freeze[i])   ctl = HOLD;
            else if (freeze[i-1]) ctl = BUBBLE;
            else                  ctl = LOAD;
         end
      end

      pipe_stage #(.WIDTH(WIDTH)) uStage (
         .clk       (clk),
         .resetn    (resetn),
         .ctl       (ctl),
         .prevValid (prevValid),
         .prevData  (prevData),
         .valid     (validQ[i]),
         .data      (dataQ[i])
      );

      assign stage_data[i*WIDTH +: WIDTH] = dataQ[i];
   end

   assign stage_valid = validQ;
   assign in_ready    = ~freeze[0];
   assign out_fire    = validQ[STAGES-1] & ~freeze[STAGES-1];

`ifdef PIPE_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_stall  <= '0;
         perf_flush  <= '0;
         perf_retire <= '0;
      end else begin
         if (freeze[0]) perf_stall  <= perf_stall + CNT_W'(1);
         if (|flush)    perf_flush  <= perf_flush + CNT_W'(1);
         if (out_fire)  perf_retire <= perf_retire + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (STAGES=4, WIDTH=8); counter checks
// run when PIPE_PERF_EN is defined.
module tb_pipe_ctrl;

   localparam int STAGES = 4;
   localparam int WIDTH  = 8;

   logic                    clk = 1'b0;
   logic                    resetn;
   logic                    in_valid;
   logic [WIDTH-1:0]        in_data;
   logic                    in_ready;
   logic [STAGES-1:0]       stall_req;
   logic [STAGES-1:0]       flush;
   logic [STAGES-1:0]       stage_valid;
   logic [STAGES*WIDTH-1:0] stage_data;
   logic                    out_fire;
`ifdef PIPE_PERF_EN
   localparam int CNT_W = 4;
   logic [CNT_W-1:0] perf_stall, perf_flush, perf_retire;
`endif

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

`ifdef PIPE_PERF_EN
   pipe_ctrl #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
`else
   pipe_ctrl #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
`endif
      .clk         (clk),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .stall_req   (stall_req),
      .flush       (flush),
      .stage_valid (stage_valid),
      .stage_data  (stage_data),
      .out_fire    (out_fire)
`ifdef PIPE_PERF_EN
      ,
      .perf_stall  (perf_stall),
      .perf_flush  (perf_flush),
      .perf_retire (perf_retire)
`endif
   );

   typedef struct {
      logic              inValid;
      logic [WIDTH-1:0]  inData;
      logic [STAGES-1:0] stall;
      logic [STAGES-1:0] flsh;
      logic              expReady;
      logic              expFire;
      logic [STAGES-1:0] expValid;
      logic [31:0]       expData;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic [3:0] st,
                               input logic [3:0] fl, input logic rdy, input logic fire,
                               input logic [3:0] v, input logic [31:0] d);
      vec_t r;
      r.inValid = iv;  r.inData = id;   r.stall = st;  r.flsh = fl;
      r.expReady = rdy; r.expFire = fire; r.expValid = v; r.expData = d;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Streaming 1..6 (in stage 3 after the fourth edge, retiring in order).
      vecs[0]  = mk(1, 8'h01, 4'b0000, 4'b0000, 1, 0, 4'b0001, 32'h00000001);
      vecs[1]  = mk(1, 8'h02, 4'b0000, 4'b0000, 1, 0, 4'b0011, 32'h00000102);
      vecs[2]  = mk(1, 8'h03, 4'b0000, 4'b0000, 1, 0, 4'b0111, 32'h00010203);
      vecs[3]  = mk(1, 8'h04, 4'b0000, 4'b0000, 1, 0, 4'b1111, 32'h01020304);
      vecs[4]  = mk(1, 8'h05, 4'b0000, 4'b0000, 1, 1, 4'b1111, 32'h02030405);
      vecs[5]  = mk(1, 8'h06, 4'b0000, 4'b0000, 1, 1, 4'b1111, 32'h03040506);
      // stall_req[2] for three cycles: 0..2 hold, stage 3 bubbles.
      vecs[6]  = mk(1, 8'h07, 4'b0100, 4'b0000, 0, 1, 4'b0111, 32'h00040506);
      vecs[7]  = mk(1, 8'h07, 4'b0100, 4'b0000, 0, 0, 4'b0111, 32'h00040506);
      vecs[8]  = mk(1, 8'h07, 4'b0100, 4'b0000, 0, 0, 4'b0111, 32'h00040506);
      vecs[9]  = mk(1, 8'h07, 4'b0000, 4'b0000, 1, 0, 4'b1111, 32'h04050607);
      vecs[10] = mk(1, 8'h08, 4'b0000, 4'b0000, 1, 1, 4'b1111, 32'h05060708);
      // flush[2]: stages 0,1 and the input are killed; stage 2 loads stage 1's pre-kill content.
      vecs[11] = mk(1, 8'h09, 4'b0000, 4'b0100, 1, 1, 4'b1100, 32'h06070000);
      vecs[12] = mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1000, 32'h07000000);
      // Refill, then flush[3] together with stall_req[1]: flush beats stall.
      vecs[13] = mk(1, 8'h11, 4'b0000, 4'b0000, 1, 1, 4'b0001, 32'h00000011);
      vecs[14] = mk(1, 8'h12, 4'b0000, 4'b0000, 1, 0, 4'b0011, 32'h00001112);
      vecs[15] = mk(1, 8'h13, 4'b0000, 4'b0000, 1, 0, 4'b0111, 32'h00111213);
      vecs[16] = mk(1, 8'h14, 4'b0000, 4'b0000, 1, 0, 4'b1111, 32'h11121314);
      vecs[17] = mk(1, 8'h15, 4'b0010, 4'b1000, 0, 1, 4'b1000, 32'h12000000);
      vecs[18] = mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b0000, 32'h00000000);
      // Stall from the oldest stage freezes the whole chain.
      vecs[19] = mk(1, 8'h21, 4'b0000, 4'b0000, 1, 0, 4'b0001, 32'h00000021);
      vecs[20] = mk(1, 8'h22, 4'b1000, 4'b0000, 0, 0, 4'b0001, 32'h00000021);
      vecs[21] = mk(0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'b0010, 32'h00002100);
      // flush[0] and flush[1] together: only stage 0 is killed.
      vecs[22] = mk(1, 8'h31, 4'b0000, 4'b0011, 1, 0, 4'b0100, 32'h00210000);
      vecs[23] = mk(0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'b1000, 32'h21000000);
      vecs[24] = mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b0000, 32'h00000000);

      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      stall_req = '0;
      flush     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", 32'(stage_valid), 32'h0);
      check("reset_data", stage_data, 32'h0);
      check("reset_ready", 32'(in_ready), 32'h1);
      check("reset_fire", 32'(out_fire), 32'h0);
`ifdef PIPE_PERF_EN
      check("reset_perf_retire", 32'(perf_retire), 32'h0);
`endif
      resetn = 1'b1;
      tick();

      for (int i = 0; i < NVEC; i++) begin
         in_valid  = vecs[i].inValid;
         in_data   = vecs[i].inData;
         stall_req = vecs[i].stall;
         flush     = vecs[i].flsh;
         #1;
         check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
         check($sformatf("v%0d_fire", i), 32'(out_fire), 32'(vecs[i].expFire));
         tick();
         check($sformatf("v%0d_valid", i), 32'(stage_valid), 32'(vecs[i].expValid));
         check($sformatf("v%0d_data", i), stage_data, vecs[i].expData);
      end

      // Asynchronous reset between edges with the pipe holding data.
      in_valid = 1'b1;
      in_data  = 8'h41;
      tick();
      in_data  = 8'h42;
      tick();
      check("pre_areset_valid", 32'(stage_valid), 32'h3);
      #2;
      resetn = 1'b0;
      #1;
      check("areset_valid", 32'(stage_valid), 32'h0);
      check("areset_data", stage_data, 32'h0);
      check("areset_fire", 32'(out_fire), 32'h0);
      check("areset_ready", 32'(in_ready), 32'h1);
      stall_req = 4'b1000;
      #1;
      check("areset_ready_stalled", 32'(in_ready), 32'h0);
`ifdef PIPE_PERF_EN
      check("areset_perf_stall", 32'(perf_stall), 32'h0);
      check("areset_perf_flush", 32'(perf_flush), 32'h0);
      check("areset_perf_retire", 32'(perf_retire), 32'h0);
`endif
      stall_req = '0;
      repeat (2) @(posedge clk);
      #1;
      check("areset_held_valid", 32'(stage_valid), 32'h0);
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge clk);
      resetn = 1'b1;
      tick();

`ifdef PIPE_PERF_EN
      // 20 streaming cycles retire 16 payloads: the 4-bit retire counter wraps to 0.
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i + 1);
         tick();
      end
      check("perf_retire_wrap", 32'(perf_retire), 32'h0);
      check("perf_stall_zero", 32'(perf_stall), 32'h0);
      stall_req = 4'b0001;
      repeat (3) tick();
      stall_req = '0;
      flush     = 4'b0010;
      tick();
      flush    = '0;
      in_valid = 1'b0;
      #1;
      check("perf_stall", 32'(perf_stall), 32'h3);
      check("perf_flush", 32'(perf_flush), 32'h1);
      check("perf_retire", 32'(perf_retire), 32'h3);
`endif

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
